cmd_framer: RTL and testbench

CMD_FRAMER -- requirements
Module: cmd_framer

---
 rtl/cmd_pkg.sv | 23 ++
 rtl/reply_fifo.sv | 60 ++++++
 rtl/cmd_framer.sv | 157 +++++++++++++++
 tb/tb_cmd_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared frame width and state encodings for the command framer.
// Imported by reply_fifo and cmd_framer.
package cmd_pkg;

  localparam int FRAME_BYTES = 3;
  localparam int FRAME_W     = 8 * FRAME_BYTES;

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [1:0] {
    RX0 = 2'd0,
    RX1 = 2'd1,
    RX2 = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_B0   = 2'd1,
    TX_B1   = 2'd2,
    TX_B2   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/reply_fifo.sv
// Reply FIFO: DEPTH frame_t entries, synchronous active-high reset.
// Ports: clk, reset, push/push_data (dropped when full), pop/pop_data
// (first-word fall-through), full, empty.
module reply_fifo
  import cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  frame_t push_data,
  input  logic   pop,
  output frame_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A push into a full FIFO is lost even if a pop frees a slot
  // in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_framer.sv
// Host command framer: packs 3 RX bytes into a command strobe and
// serialises queued 24-bit replies back to the host, MSB byte first.
// Ports: i_command_clk, i_reset (sync, high), i_rx_byte/i_rx_valid,
// o_command/o_command_data, i_reply/i_reply_data, o_overflow,
// o_tx_byte/o_tx_valid/i_tx_ready.
// Define CMD_FRAMER_TIMEOUT_EN to drop partial frames after
// TIMEOUT_CYCLES idle clocks.
module cmd_framer
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_command_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_byte,
  input  logic               i_rx_valid,
  output logic               o_command,
  output logic [FRAME_W-1:0] o_command_data,
  input  logic               i_reply,
  input  logic [FRAME_W-1:0] i_reply_data,
  output logic               o_overflow,
  output logic [7:0]         o_tx_byte,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cmd_framer: illegal parameter value");
  end

  // ---------------- RX framing ----------------
  rx_state_t          rx_state;
  rx_state_t          rx_next;
  logic [FRAME_W-9:0] frame_lo;
  logic               timeout_hit;

  always_ff @(posedge i_command_clk) begin
    if (i_reset) rx_state <= RX0;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (i_rx_valid) begin
      unique case (rx_state)
        RX0:     rx_next = RX1;
        RX1:     rx_next = RX2;
        default: rx_next = RX0;
      endcase
    end else if (timeout_hit) begin
      rx_next = RX0;
    end
  end

  // Only the first two bytes are buffered; the third is taken
  // straight from i_rx_byte when the frame completes.
  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      frame_lo       <= '0;
      o_command      <= 1'b0;
      o_command_data <= '0;
    end else begin
      o_command <= 1'b0;
      if (i_rx_valid) begin
        frame_lo <= {frame_lo[7:0], i_rx_byte};
        if (rx_state == RX2) begin
          o_command      <= 1'b1;
          o_command_data <= {frame_lo, i_rx_byte};
        end
      end
    end
  end

`ifdef CMD_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  assign timeout_hit = !i_rx_valid && (rx_state != RX0) &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (i_rx_valid || rx_state == RX0 || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------- reply FIFO ----------------
  frame_t fifo_data;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;

  reply_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_command_clk),
    .reset     (i_reset),
    .push      (i_reply),
    .push_data (i_reply_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_overflow = fifo_full;

  // ---------------- TX serialiser ----------------
  tx_state_t tx_state;
  tx_state_t tx_next;
  frame_t    tx_shift;
  logic      tx_accept;

  assign o_tx_valid = (tx_state != TX_IDLE);
  assign o_tx_byte  = tx_shift[FRAME_W-1 -: 8];
  assign tx_accept  = o_tx_valid && i_tx_ready;
  assign fifo_pop   = (tx_state == TX_IDLE) && !fifo_empty;

  always_ff @(posedge i_command_clk) begin
    if (i_reset) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE: if (!fifo_empty) tx_next = TX_B0;
      TX_B0:   if (tx_accept)   tx_next = TX_B1;
      TX_B1:   if (tx_accept)   tx_next = TX_B2;
      default: if (tx_accept)   tx_next = TX_IDLE;
    endcase
  end

  // Shift left on each accepted byte so the top byte is always
  // the one on the wire; it holds while the sink stalls.
  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      tx_shift <= '0;
    end else if (fifo_pop) begin
      tx_shift <= fifo_data;
    end else if (tx_accept) begin
      tx_shift <= {tx_shift[FRAME_W-9:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_cmd_framer.sv
// Self-checking bench for cmd_framer: vector tables plus scoreboard
// queues for commands and transmitted bytes.
module tb_cmd_framer;

  logic        clk;
  logic        i_reset;
  logic [7:0]  i_rx_byte;
  logic        i_rx_valid;
  logic        o_command;
  logic [23:0] o_command_data;
  logic        i_reply;
  logic [23:0] i_reply_data;
  logic        o_overflow;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_ready;

  cmd_framer #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .i_command_clk  (clk),
    .i_reset        (i_reset),
    .i_rx_byte      (i_rx_byte),
    .i_rx_valid     (i_rx_valid),
    .o_command      (o_command),
    .o_command_data (o_command_data),
    .i_reply        (i_reply),
    .i_reply_data   (i_reply_data),
    .o_overflow     (o_overflow),
    .o_tx_byte      (o_tx_byte),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  logic [23:0] cmd_q[$];

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [23:0] w);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_reply(input logic [23:0] w, input bit kept);
    if (kept) push_exp(w);
    i_reply      = 1'b1;
    i_reply_data = w;
    tick();
    i_reply = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Command monitor: one-cycle strobe, data matches the next
  // expected frame, data held between strobes.
  logic [23:0] last_cmd;
  logic        prev_cmd;
  always @(negedge clk) begin
    if (i_reset) begin
      last_cmd = '0;
      prev_cmd = 1'b0;
    end else begin
      if (o_command) begin
        check("cmd_pulse_width", prev_cmd, 0);
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", o_command, 0);
        end else begin
          last_cmd = cmd_q.pop_front();
          check("cmd_data", o_command_data, last_cmd);
        end
      end else begin
        check("cmd_hold", o_command_data, last_cmd);
      end
      prev_cmd = o_command;
    end
  end

  // TX monitor: accepted bytes leave in order; stalled bytes hold.
  logic       prev_stall;
  logic [7:0] prev_byte;
  always @(negedge clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
      prev_byte  = '0;
    end else begin
      if (prev_stall) begin
        check("tx_stall_valid", o_tx_valid, 1);
        check("tx_stall_byte", o_tx_byte, prev_byte);
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) check("tx_unexpected", o_tx_byte, 0);
        else check("tx_byte", o_tx_byte, exp_q.pop_front());
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_byte  = o_tx_byte;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          gap;
    logic [23:0] exp;
  } cmd_vec_t;

  cmd_vec_t    cmd_tab[4];
  logic [23:0] rep_tab[3];

  initial begin
    cmd_tab[0] = '{8'h57, 8'h12, 8'h34, 0, 24'h571234};
    cmd_tab[1] = '{8'h52, 8'h00, 8'h00, 2, 24'h520000};
    cmd_tab[2] = '{8'hFF, 8'h80, 8'h01, 0, 24'hFF8001};
    cmd_tab[3] = '{8'h78, 8'hA5, 8'h5A, 5, 24'h78A55A};
    rep_tab[0] = 24'h01ABCD;
    rep_tab[1] = 24'h800000;
    rep_tab[2] = 24'h00FFEE;

    // Reset with RX and reply activity that must be ignored.
    i_reset      = 1'b1;
    i_rx_byte    = 8'hEE;
    i_rx_valid   = 1'b1;
    i_reply      = 1'b1;
    i_reply_data = 24'hDEAD01;
    i_tx_ready   = 1'b0;
    repeat (3) tick();
    i_reset    = 1'b0;
    i_rx_valid = 1'b0;
    i_reply    = 1'b0;
    tick();
    check("rst_command", o_command, 0);
    check("rst_command_data", o_command_data, 0);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_byte", o_tx_byte, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_count", u_dut.u_fifo.count, 0);

    // Command frames, with and without gaps between bytes.
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back(cmd_tab[i].exp);
      send_byte(cmd_tab[i].b0);
      repeat (cmd_tab[i].gap) tick();
      send_byte(cmd_tab[i].b1);
      repeat (cmd_tab[i].gap) tick();
      send_byte(cmd_tab[i].b2);
    end
    repeat (3) tick();
    check("cmd_all_seen", cmd_q.size(), 0);

    // Reply latency, then a stall-heavy handshake.
    push_reply(rep_tab[0], 1'b1);
    check("lat_n1_valid", o_tx_valid, 0);
    tick();
    check("lat_n2_valid", o_tx_valid, 1);
    check("lat_n2_byte", o_tx_byte, 8'h01);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      i_tx_ready = !i_tx_ready;
      tick();
    end
    check("toggle_drained", exp_q.size(), 0);
    i_tx_ready = 1'b1;
    for (int i = 1; i < 3; i++) push_reply(rep_tab[i], 1'b1);
    drain("rep_drain", 50);
    repeat (2) tick();

    // Overflow: the first reply moves straight into the TX shifter,
    // so the FIFO holds the next eight and the tenth push is lost.
    i_tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("ovf_before_push", o_overflow, (k == 9));
      push_reply({8'(k), 8'(8'hC0 + k), 8'h5A}, (k < 9));
    end
    check("ovf_held", o_overflow, 1);
    check("ovf_count", u_dut.u_fifo.count, 8);
    i_tx_ready = 1'b1;
    drain("ovf_drain", 200);
    tick();
    check("ovf_cleared", o_overflow, 0);
    check("ovf_count_empty", u_dut.u_fifo.count, 0);

    // Simultaneous push and pop with four entries queued.
    i_tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_reply({8'hB0, 8'(k), 8'h11}, 1'b1);
    check("pp_count_setup", u_dut.u_fifo.count, 4);
    i_tx_ready = 1'b1;
    for (int n = 0; n < 10 && o_tx_valid; n++) tick();
    check("pp_idle", o_tx_valid, 0);
    check("pp_count_before", u_dut.u_fifo.count, 4);
    push_reply(24'hB05566, 1'b1);
    check("pp_count_after", u_dut.u_fifo.count, 4);
    check("pp_overflow", o_overflow, 0);
    drain("pp_drain", 100);

    // Partial frame followed by a long idle gap.
`ifdef CMD_FRAMER_TIMEOUT_EN
    cmd_q.push_back(24'h420003);
    send_byte(8'h61);
    repeat (20) tick();
    send_byte(8'h42);
    send_byte(8'h00);
    send_byte(8'h03);
`else
    cmd_q.push_back(24'h614200);
    send_byte(8'h61);
    repeat (20) tick();
    send_byte(8'h42);
    send_byte(8'h00);
`endif
    repeat (3) tick();
    check("idle_cmd_seen", cmd_q.size(), 0);

    // Reset mid-frame and mid-reply.
    i_tx_ready = 1'b0;
    push_reply(24'h0A0B0C, 1'b1);
    for (int n = 0; n < 5 && !o_tx_valid; n++) tick();
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    check("mid_tx_b1_byte", o_tx_byte, 8'h0B);
    send_byte(8'h11);
    send_byte(8'h22);
    exp_q.delete();
    i_reset      = 1'b1;
    i_rx_byte    = 8'h99;
    i_rx_valid   = 1'b1;
    i_reply      = 1'b1;
    i_reply_data = 24'h123456;
    tick();
    i_reset    = 1'b0;
    i_rx_valid = 1'b0;
    i_reply    = 1'b0;
    check("mid_rst_tx_valid", o_tx_valid, 0);
    check("mid_rst_tx_byte", o_tx_byte, 0);
    check("mid_rst_command", o_command, 0);
    check("mid_rst_cmd_data", o_command_data, 0);
    check("mid_rst_count", u_dut.u_fifo.count, 0);
    i_tx_ready = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_tx", o_tx_valid, 0);
    cmd_q.push_back(24'h435566);
    send_byte(8'h43);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (3) tick();
    check("mid_rst_fresh_cmd", cmd_q.size(), 0);
    check("end_tx_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
